// File: rtl/custom_instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : custom_instr_pkg
// Description : Shared types and constants for the custom-instruction
//               datapath units (run-length counter FSM states, scan
//               direction encodings).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package custom_instr_pkg;

    // Run-length counter FSM states
    typedef enum logic [1:0] {
        RLC_IDLE = 2'd0,
        RLC_EXEC = 2'd1,
        RLC_DONE = 2'd2
    } rlc_state_e;

    // Scan direction encodings
    localparam logic RLC_DIR_LSB = 1'b0;
    localparam logic RLC_DIR_MSB = 1'b1;

endpackage : custom_instr_pkg
`default_nettype wire

// File: rtl/run_chunk_scan.sv
`default_nettype none
// ============================================================================
// Module      : run_chunk_scan
// Description : Combinational chunk scanner. Starting at bit pos_i of word_i
//               and stepping in direction dir_i, counts how many consecutive
//               bits equal t_i, examining at most min(CHUNK, avail_i) bits.
// Ports       : word_i  - latched operand word
//               pos_i   - current scan position (IDXW+1 bits)
//               dir_i   - 0 = toward LSB, 1 = toward MSB
//               t_i     - target bit value
//               avail_i - bits left before the word edge (IDXW+1 bits)
//               n_o     - number of matching bits found in this chunk
// Revision    : 1.0 - initial release
// ============================================================================
module run_chunk_scan
    import custom_instr_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic [XLEN-1:0]          word_i,
    input  logic [$clog2(XLEN):0]    pos_i,
    input  logic                     dir_i,
    input  logic                     t_i,
    input  logic [$clog2(XLEN):0]    avail_i,
    output logic [$clog2(XLEN):0]    n_o
);

    localparam int IDXW = $clog2(XLEN);
    localparam int CW   = IDXW + 1;

    logic          run;
    logic [CW-1:0] p;
    logic [CW-1:0] cnt;

    // The run flag drops at the first mismatch or when the word edge is
    // reached; positions past the edge are never allowed to contribute
    // because the avail_i check short-circuits the bit comparison.
    always_comb begin
        cnt = '0;
        run = 1'b1;
        p   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            p = (dir_i == RLC_DIR_MSB) ? (pos_i + CW'(i)) : (pos_i - CW'(i));
            if (run && (CW'(i) < avail_i) && (word_i[p[IDXW-1:0]] == t_i)) begin
                cnt = cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign n_o = cnt;

endmodule : run_chunk_scan
`default_nettype wire

// File: rtl/run_length_cnt.sv
`default_nettype none
// ============================================================================
// Module      : run_length_cnt
// Description : Multi-cycle custom-instruction unit returning the length of
//               the run of bits in rs0 equal to rs0[idx], counted from idx
//               inclusive. Scans CHUNK bits per cycle; start/done handshake.
//               Optional macro RUN_CNT_BOTH_DIR_EN adds the dir_i port and
//               MSB-ward scanning; without it the scan is toward LSB only.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               start_i - start request, sampled only in IDLE
//               rs0_i   - operand to scan
//               rs1_i   - start index (low IDXW bits, clipped to XLEN-1)
//               dir_i   - scan direction (RUN_CNT_BOTH_DIR_EN only)
//               busy_o  - high in EXEC and DONE
//               done_o  - one-cycle pulse, result valid
//               rd_o    - run length, held until next result
// Revision    : 1.0 - initial release
// ============================================================================
module run_length_cnt
    import custom_instr_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [XLEN-1:0] rs0_i,
    input  logic [XLEN-1:0] rs1_i,
`ifdef RUN_CNT_BOTH_DIR_EN
    input  logic            dir_i,
`endif
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] rd_o
);

    localparam int IDXW = $clog2(XLEN);
    localparam int CW   = IDXW + 1;

    rlc_state_e      state_q, state_d;
    logic [XLEN-1:0] word_q,  word_d;
    logic [CW-1:0]   pos_q,   pos_d;
    logic            dir_q,   dir_d;
    logic            t_q,     t_d;
    logic [CW-1:0]   acc_q,   acc_d;
    logic [CW-1:0]   rem_q,   rem_d;
    logic [XLEN-1:0] rd_q,    rd_d;

    logic [IDXW-1:0] idx_raw;
    logic [IDXW-1:0] idx;
    logic            dir_in;
    logic [CW-1:0]   avail;
    logic [CW-1:0]   n;
    logic            unused_rs1;

    assign idx_raw    = rs1_i[IDXW-1:0];
    assign unused_rs1 = ^rs1_i[XLEN-1:IDXW];

    // Clipping only matters when XLEN is not a power of two.
    generate
        if (XLEN == (1 << IDXW)) begin : g_idx_pow2
            assign idx = idx_raw;
        end else begin : g_idx_clip
            assign idx = (idx_raw > IDXW'(XLEN-1)) ? IDXW'(XLEN-1) : idx_raw;
        end
    endgenerate

`ifdef RUN_CNT_BOTH_DIR_EN
    assign dir_in = dir_i;
`else
    assign dir_in = RLC_DIR_LSB;
`endif

    assign avail = (rem_q < CW'(CHUNK)) ? rem_q : CW'(CHUNK);

    run_chunk_scan #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK)
    ) u_scan (
        .word_i  (word_q),
        .pos_i   (pos_q),
        .dir_i   (dir_q),
        .t_i     (t_q),
        .avail_i (avail),
        .n_o     (n)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        t_d     = t_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        rd_d    = rd_q;

        unique case (state_q)
            RLC_IDLE: begin
                if (start_i) begin
                    word_d  = rs0_i;
                    dir_d   = dir_in;
                    t_d     = rs0_i[idx];
                    pos_d   = {1'b0, idx};
                    acc_d   = '0;
                    rem_d   = (dir_in == RLC_DIR_MSB) ? (CW'(XLEN) - {1'b0, idx})
                                                      : ({1'b0, idx} + CW'(1));
                    state_d = RLC_EXEC;
                end
            end
            RLC_EXEC: begin
                acc_d = acc_q + n;
                rem_d = rem_q - n;
                pos_d = (dir_q == RLC_DIR_MSB) ? (pos_q + n) : (pos_q - n);
                // A full chunk of matches with bits still left means the run
                // may continue; anything shorter ends the scan.
                if ((n == CW'(CHUNK)) && (rem_d != '0)) begin
                    state_d = RLC_EXEC;
                end else begin
                    rd_d    = XLEN'(acc_d);
                    state_d = RLC_DONE;
                end
            end
            RLC_DONE: begin
                state_d = RLC_IDLE;
            end
            default: begin
                state_d = RLC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RLC_IDLE;
            word_q  <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            t_q     <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            rd_q    <= rd_d;
        end
    end

    assign busy_o = (state_q != RLC_IDLE);
    assign done_o = (state_q == RLC_DONE);
    assign rd_o   = rd_q;

endmodule : run_length_cnt
`default_nettype wire
